exwb_pipe_reg: RTL and testbench

Parametrised EX/WB pipeline register for the single-cycle-per-stage datapath. It carries ALU result, data-memory read data, PC/jump address, destination register and the nine-bit control bundle through DEPTH register stages. It adds per-stage valid tracking, stall (hold) and flush (bubble insertion). It sits between the execute/memory logic and the writeback/branch-resolve logic and replaces a plain latch-everything register.

---
 rtl/exwb_pipe_reg.sv | 140 ++++++++++++++
 tb/tb_exwb_pipe_reg.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exwb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : exwb_pipe_reg
// Purpose  : EX/WB pipeline register, DEPTH cascaded stages clocked on the
//            falling edge. Carries ALU result, memory read data, PC/jump
//            address, destination register and the control bundle, with
//            per-stage valid tracking, stall (hold) and flush (bubble).
//            Optional macro EXWB_PIPE_STATS_EN adds stall/bubble counters.
// Revision : 1.0 - initial release
// ============================================================================
module exwb_pipe_reg #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 6,
    parameter int CTRL_W = 9,
    parameter int DEPTH  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] alu,
    input  logic [DATA_W-1:0] datamem,
    input  logic [DATA_W-1:0] addr,
    input  logic [RD_W-1:0]   rd,
    input  logic [CTRL_W-1:0] ctrl,
`ifdef EXWB_PIPE_STATS_EN
    output logic [15:0]       stall_cnt,
    output logic [15:0]       bubble_cnt,
`endif
    output logic              valid_out,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] data_mem_out,
    output logic [DATA_W-1:0] addr_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [CTRL_W-1:0] ctrl_out
);

    // Reject unsupported pipeline depths at elaboration time.
    if ((DEPTH < 1) || (DEPTH > 4)) begin : g_depth_check
        $fatal(1, "exwb_pipe_reg: DEPTH must be in 1..4");
    end

    // Stage registers; index DEPTH-1 is the stage that drives the outputs.
    logic [DEPTH-1:0]             r_v;
    logic [DEPTH-1:0][DATA_W-1:0] r_alu;
    logic [DEPTH-1:0][DATA_W-1:0] r_dm;
    logic [DEPTH-1:0][DATA_W-1:0] r_addr;
    logic [DEPTH-1:0][RD_W-1:0]   r_rd;
    logic [DEPTH-1:0][CTRL_W-1:0] r_ctrl;

    // Value each stage loads on an advance edge.
    logic [DEPTH-1:0]             w_v_src;
    logic [DEPTH-1:0][DATA_W-1:0] w_alu_src;
    logic [DEPTH-1:0][DATA_W-1:0] w_dm_src;
    logic [DEPTH-1:0][DATA_W-1:0] w_addr_src;
    logic [DEPTH-1:0][RD_W-1:0]   w_rd_src;
    logic [DEPTH-1:0][CTRL_W-1:0] w_ctrl_src;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage_src
        if (k == 0) begin : g_head
            // Control is squashed on entry so a bubble can never carry
            // reg_write/branch/jump bits down the pipe.
            assign w_v_src[k]    = valid_in;
            assign w_alu_src[k]  = alu;
            assign w_dm_src[k]   = datamem;
            assign w_addr_src[k] = addr;
            assign w_rd_src[k]   = rd;
            assign w_ctrl_src[k] = valid_in ? ctrl : '0;
        end else begin : g_chain
            assign w_v_src[k]    = r_v[k-1];
            assign w_alu_src[k]  = r_alu[k-1];
            assign w_dm_src[k]   = r_dm[k-1];
            assign w_addr_src[k] = r_addr[k-1];
            assign w_rd_src[k]   = r_rd[k-1];
            assign w_ctrl_src[k] = r_ctrl[k-1];
        end
    end

    // Stage update: flush clears valid/control only, stall holds, else shift.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v    <= '0;
            r_alu  <= '0;
            r_dm   <= '0;
            r_addr <= '0;
            r_rd   <= '0;
            r_ctrl <= '0;
        end else if (flush) begin
            r_v    <= '0;
            r_ctrl <= '0;
        end else if (!stall) begin
            r_v    <= w_v_src;
            r_alu  <= w_alu_src;
            r_dm   <= w_dm_src;
            r_addr <= w_addr_src;
            r_rd   <= w_rd_src;
            r_ctrl <= w_ctrl_src;
        end
    end

    assign valid_out    = r_v[DEPTH-1];
    assign alu_out      = r_alu[DEPTH-1];
    assign data_mem_out = r_dm[DEPTH-1];
    assign addr_out     = r_addr[DEPTH-1];
    assign rd_out       = r_rd[DEPTH-1];
    assign ctrl_out     = r_ctrl[DEPTH-1];

`ifdef EXWB_PIPE_STATS_EN
    logic [15:0] r_stall_cnt;
    logic [15:0] r_bubble_cnt;
    logic        w_stall_edge;
    logic        w_bubble_edge;

    // A bubble edge leaves the last stage invalid: any flush, or an advance
    // that shifts an invalid entry into the last stage.
    assign w_stall_edge  = stall & ~flush;
    assign w_bubble_edge = flush | (~stall & ~w_v_src[DEPTH-1]);

    // Saturating event counters.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (w_stall_edge && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_bubble_edge && (r_bubble_cnt != 16'hFFFF)) begin
                r_bubble_cnt <= r_bubble_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt  = r_stall_cnt;
    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exwb_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_exwb_pipe_reg
// Purpose  : Self-checking bench for exwb_pipe_reg. One instance per DEPTH
//            (1..4) shares the stimulus; a history-queue model predicts the
//            last-stage contents of every depth after each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exwb_pipe_reg;

    typedef struct packed {
        logic        v;
        logic [31:0] alu;
        logic [31:0] dm;
        logic [31:0] ad;
        logic [5:0]  rd;
        logic [8:0]  ctrl;
    } ent_t;

    logic        clk;
    logic        r_rst_n;
    logic        r_stall;
    logic        r_flush;
    logic        r_valid;
    logic [31:0] r_alu;
    logic [31:0] r_dm;
    logic [31:0] r_addr;
    logic [5:0]  r_rd;
    logic [8:0]  r_ctrl;

    logic [3:0]        w_vo;
    logic [3:0][31:0]  w_ao;
    logic [3:0][31:0]  w_do;
    logic [3:0][31:0]  w_ad;
    logic [3:0][5:0]   w_ro;
    logic [3:0][8:0]   w_co;
`ifdef EXWB_PIPE_STATS_EN
    logic [3:0][15:0]  w_sc;
    logic [3:0][15:0]  w_bc;
`endif

    for (genvar d = 0; d < 4; d++) begin : g_dut
        exwb_pipe_reg #(
            .DATA_W(32), .RD_W(6), .CTRL_W(9), .DEPTH(d + 1)
        ) u_dut (
            .clk          (clk),
            .rst_n        (r_rst_n),
            .stall        (r_stall),
            .flush        (r_flush),
            .valid_in     (r_valid),
            .alu          (r_alu),
            .datamem      (r_dm),
            .addr         (r_addr),
            .rd           (r_rd),
            .ctrl         (r_ctrl),
`ifdef EXWB_PIPE_STATS_EN
            .stall_cnt    (w_sc[d]),
            .bubble_cnt   (w_bc[d]),
`endif
            .valid_out    (w_vo[d]),
            .alu_out      (w_ao[d]),
            .data_mem_out (w_do[d]),
            .addr_out     (w_ad[d]),
            .rd_out       (w_ro[d]),
            .ctrl_out     (w_co[d])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_bad = 0;

    // Model: entries accepted on advance edges, newest at the back. The
    // last stage of a DEPTH-D pipe holds the D-th newest entry (zero if
    // fewer were accepted since reset). Flush invalidates whatever is held.
    ent_t hist[$];
    int   m_sc;
    int   m_bc[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        hist.delete();
        m_sc = 0;
        for (int d = 0; d < 4; d++) m_bc[d] = 0;
    endtask

    function automatic ent_t model_last(input int depth);
        ent_t e;
        e = '0;
        if (hist.size() >= depth) e = hist[hist.size() - depth];
        return e;
    endfunction

    task automatic model_edge();
        ent_t e;
        ent_t l;
        if (r_flush) begin
            foreach (hist[i]) begin
                hist[i].v    = 1'b0;
                hist[i].ctrl = '0;
            end
            for (int d = 0; d < 4; d++) if (m_bc[d] < 65535) m_bc[d]++;
        end else if (r_stall) begin
            if (m_sc < 65535) m_sc++;
        end else begin
            e.v    = r_valid;
            e.alu  = r_alu;
            e.dm   = r_dm;
            e.ad   = r_addr;
            e.rd   = r_rd;
            e.ctrl = r_valid ? r_ctrl : 9'd0;
            hist.push_back(e);
            if (hist.size() > 4) void'(hist.pop_front());
            for (int d = 0; d < 4; d++) begin
                l = model_last(d + 1);
                if (!l.v && m_bc[d] < 65535) m_bc[d]++;
            end
        end
    endtask

    task automatic compare_all();
        ent_t act;
        for (int d = 0; d < 4; d++) begin
            act = {w_vo[d], w_ao[d], w_do[d], w_ad[d], w_ro[d], w_co[d]};
            chk($sformatf("bundle_d%0d", d + 1), 128'(act), 128'(model_last(d + 1)));
`ifdef EXWB_PIPE_STATS_EN
            chk($sformatf("stall_cnt_d%0d", d + 1), 128'(w_sc[d]), 128'(m_sc));
            chk($sformatf("bubble_cnt_d%0d", d + 1), 128'(w_bc[d]), 128'(m_bc[d]));
`endif
        end
    endtask

    // One falling edge: update the model with the inputs the DUTs capture,
    // then compare everything shortly after the edge.
    task automatic tick();
        @(negedge clk);
        if (r_rst_n) model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse_reset();
        #2;
        r_rst_n = 1'b0;
        model_clear();
        #1;
        compare_all();
        r_rst_n = 1'b1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [5:0] r,
                         input logic [8:0] c, input logic st, input logic fl);
        r_valid = v;
        r_alu   = a;
        r_dm    = a ^ 32'h5A5A_0000;
        r_addr  = a + 32'h0000_1000;
        r_rd    = r;
        r_ctrl  = c;
        r_stall = st;
        r_flush = fl;
    endtask

    initial begin
        r_rst_n = 1'b0;
        model_clear();
        drive(1'b1, 32'hFFFF_FFFF, 6'h3F, 9'h1FF, 1'b0, 1'b0);
        #2;
        r_rst_n = 1'b1;

        // Fill every pipe with all-ones bundles, then reset with no clock.
        repeat (4) tick();
        chk("full_before_reset_valid", 128'(w_vo), 128'(4'hF));
        chk("full_before_reset_alu_d4", 128'(w_ao[3]), 128'(32'hFFFF_FFFF));
        r_stall = 1'b1;
        r_flush = 1'b1;
        pulse_reset();
        chk("async_reset_valid", 128'(w_vo), 128'(4'h0));
        chk("async_reset_alu", 128'(w_ao), 128'(0));
        chk("async_reset_ctrl", 128'(w_co), 128'(0));

        // DEPTH=1 pass-through.
        drive(1'b1, 32'h0000_00A5, 6'd7, 9'b000000100, 1'b0, 1'b0);
        tick();
        chk("d1_pass_valid", 128'(w_vo[0]), 128'(1'b1));
        chk("d1_pass_alu", 128'(w_ao[0]), 128'(32'hA5));
        chk("d1_pass_rd", 128'(w_ro[0]), 128'(6'd7));
        chk("d1_pass_regwrite", 128'(w_co[0][2]), 128'(1'b1));

        // DEPTH=3 latency from a freshly reset pipe.
        pulse_reset();
        drive(1'b1, 32'd1, 6'd1, 9'h004, 1'b0, 1'b0);
        tick();
        chk("d1_after_reset_alu", 128'(w_ao[0]), 128'(32'd1));
        chk("d3_lat_valid_e1", 128'(w_vo[2]), 128'(1'b0));
        drive(1'b1, 32'd2, 6'd2, 9'h004, 1'b0, 1'b0);
        tick();
        chk("d3_lat_valid_e2", 128'(w_vo[2]), 128'(1'b0));
        drive(1'b1, 32'd3, 6'd3, 9'h004, 1'b0, 1'b0);
        tick();
        chk("d3_lat_alu_e3", 128'(w_ao[2]), 128'(32'd1));
        chk("d3_lat_valid_e3", 128'(w_vo[2]), 128'(1'b1));
        drive(1'b0, 32'd0, 6'd0, 9'h000, 1'b0, 1'b0);
        tick();
        chk("d3_lat_alu_e4", 128'(w_ao[2]), 128'(32'd2));
        tick();
        chk("d3_lat_alu_e5", 128'(w_ao[2]), 128'(32'd3));

        // Stall on DEPTH=2 holding 11 (last stage) and 10.
        drive(1'b1, 32'd11, 6'd11, 9'h004, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'd10, 6'd10, 9'h004, 1'b0, 1'b0);
        tick();
        chk("d2_stall_pre", 128'(w_ao[1]), 128'(32'd11));
        drive(1'b1, 32'd99, 6'd9, 9'h004, 1'b1, 1'b0);
        tick();
        chk("d2_stall_e1", 128'(w_ao[1]), 128'(32'd11));
        tick();
        chk("d2_stall_e2", 128'(w_ao[1]), 128'(32'd11));
        r_stall = 1'b0;
        tick();
        chk("d2_release_e1", 128'(w_ao[1]), 128'(32'd10));
        drive(1'b0, 32'd0, 6'd0, 9'h000, 1'b0, 1'b0);
        tick();
        chk("d2_release_e2", 128'(w_ao[1]), 128'(32'd99));

        // Flush with simultaneous stall over pipes full of ctrl=1FF.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h20 + 32'(i), 6'(i), 9'h1FF, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 32'h55, 6'd5, 9'h1FF, 1'b1, 1'b1);
        tick();
        chk("flush_valid", 128'(w_vo), 128'(4'h0));
        chk("flush_ctrl", 128'(w_co), 128'(0));
        chk("flush_data_held_d4", 128'(w_ao[3]), 128'(32'h20));
        drive(1'b1, 32'h77, 6'd12, 9'h0C3, 1'b0, 1'b0);
        tick();
        chk("post_flush_d1_valid", 128'(w_vo[0]), 128'(1'b1));
        chk("post_flush_d1_ctrl", 128'(w_co[0]), 128'(9'h0C3));
        chk("post_flush_d2_valid", 128'(w_vo[1]), 128'(1'b0));
        drive(1'b0, 32'h0, 6'd0, 9'h1FF, 1'b0, 1'b0);
        tick();
        tick();
        chk("post_flush_d3_alu", 128'(w_ao[2]), 128'(32'h77));
        chk("post_flush_d3_valid", 128'(w_vo[2]), 128'(1'b1));
        chk("bubble_ctrl_squashed_d1", 128'(w_co[0]), 128'(9'h000));

        // Mixed directed pattern of valid/bubble/stall/flush.
        for (int i = 0; i < 28; i++) begin
            drive((i % 3) != 1, 32'(i) * 32'h0101_0101, 6'(i + 3), 9'((i * 37) % 512),
                  (i % 5) == 3, (i % 7) == 6);
            tick();
        end

`ifdef EXWB_PIPE_STATS_EN
        // Three stall edges, then two bubble advance edges.
        pulse_reset();
        drive(1'b1, 32'h1, 6'd1, 9'h004, 1'b1, 1'b0);
        repeat (3) tick();
        drive(1'b0, 32'h0, 6'd0, 9'h000, 1'b0, 1'b0);
        repeat (2) tick();
        chk("stats_stall_cnt", 128'(w_sc[0]), 128'(16'd3));
        chk("stats_bubble_cnt", 128'(w_bc[0]), 128'(16'd2));
        r_stall = 1'b1;
        repeat (65540) tick();
        chk("stats_stall_sat", 128'(w_sc[3]), 128'(16'hFFFF));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
